regwb_arbiter: RTL and testbench

- Shares the register file's single write port (wr/wdata/regw) between two writeback sources. Source A is the ALU path; source B is the load/multi-cycle path.
- Each source has a 1-entry holding buffer and a valid/ready handshake.
- Arbitration is fixed priority to A, with an aging override for B.
- Exports a 32-bit pending-write busy vector for hazard detection in the issue logic.

---
 rtl/regwb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regwb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: shares the register file's single write port between two
// writeback sources. Source A is the ALU path, source B the load/multi-cycle
// path. Each source owns a 1-entry holding buffer. Arbitration is fixed
// priority to A, except that B wins once it has waited MAX_WAIT cycles, and
// two entries for the same register always retire oldest first.
//
// Handshake: a transfer happens on the posedge where x_valid && x_ready.
// x_ready is high when buffer x is empty or is being granted this cycle, so a
// source that keeps winning can issue one write per cycle. The source must
// hold x_addr/x_data stable while x_valid is high and x_ready is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_valid/a_ready          source A handshake
//   a_addr, a_data           source A destination register and data
//   b_valid/b_ready          source B handshake
//   b_addr, b_data           source B destination register and data
//   regw, wr, wdata          registered register-file write port
//   busy                     per-register pending-write vector
//   q_addr, q_hit, q_data    forwarding lookup (only with REGWB_BYPASS_EN)
//
// Optional feature macro: REGWB_BYPASS_EN adds the forwarding lookup.

module regwb_arbiter #(
    parameter int MAX_WAIT   = 4,
    parameter bit R0_DISCARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        regw,
    output logic [4:0]  wr,
    output logic [31:0] wdata,
    output logic [31:0] busy
`ifdef REGWB_BYPASS_EN
    ,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
`endif
);

    // Holding buffers
    logic        a_v, b_v;
    logic [4:0]  a_ad, b_ad;
    logic [31:0] a_dt, b_dt;
    // Cycles B has been pending without a grant (saturating)
    logic [3:0]  wait_cnt;
    // 1 when B's entry was captured before A's (or on the same edge)
    logic        age_b;

    logic gnt_a, gnt_b;
    logic a_fire, b_fire, a_load, b_load;
    logic a_v_n, b_v_n;

    always_comb begin
        gnt_b = 1'b0;
        if (b_v) begin
            if (!a_v)
                gnt_b = 1'b1;
            else if (a_ad == b_ad)
                gnt_b = age_b;
            else
                gnt_b = (wait_cnt >= 4'(MAX_WAIT));
        end
        gnt_a = a_v && !gnt_b;
    end

    assign a_ready = !a_v || gnt_a;
    assign b_ready = !b_v || gnt_b;
    assign a_fire  = a_valid && a_ready;
    assign b_fire  = b_valid && b_ready;

    // Register-0 writes are accepted but never occupy a buffer or the port.
    assign a_load = a_fire && !(R0_DISCARD && (a_addr == 5'd0));
    assign b_load = b_fire && !(R0_DISCARD && (b_addr == 5'd0));

    // A transfer always lands in a buffer that is empty or being granted, so
    // the buffer's next state is simply whether the new entry was kept.
    assign a_v_n = a_fire ? a_load : (a_v && !gnt_a);
    assign b_v_n = b_fire ? b_load : (b_v && !gnt_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v      <= 1'b0;
            b_v      <= 1'b0;
            a_ad     <= 5'd0;
            b_ad     <= 5'd0;
            a_dt     <= 32'd0;
            b_dt     <= 32'd0;
            wait_cnt <= 4'd0;
            age_b    <= 1'b0;
            regw     <= 1'b0;
            wr       <= 5'd0;
            wdata    <= 32'd0;
        end else begin
            a_v <= a_v_n;
            b_v <= b_v_n;
            if (a_load) begin
                a_ad <= a_addr;
                a_dt <= a_data;
            end
            if (b_load) begin
                b_ad <= b_addr;
                b_dt <= b_data;
            end

            // The entry that stays while the other is refilled is the older.
            if (a_load && (b_load || b_v_n))
                age_b <= 1'b1;
            else if (b_load && a_v_n)
                age_b <= 1'b0;

            if (gnt_b || !b_v)
                wait_cnt <= 4'd0;
            else if (wait_cnt != 4'd15)
                wait_cnt <= wait_cnt + 4'd1;

            // wr/wdata hold their last values on idle cycles.
            if (gnt_a) begin
                regw  <= 1'b1;
                wr    <= a_ad;
                wdata <= a_dt;
            end else if (gnt_b) begin
                regw  <= 1'b1;
                wr    <= b_ad;
                wdata <= b_dt;
            end else begin
                regw  <= 1'b0;
            end
        end
    end

    // Built from registered state only; no path from a_valid/b_valid.
    always_comb begin
        busy = 32'd0;
        if (a_v)
            busy[a_ad] = 1'b1;
        if (b_v)
            busy[b_ad] = 1'b1;
        if (regw)
            busy[wr] = 1'b1;
        if (R0_DISCARD)
            busy[0] = 1'b0;
    end

`ifdef REGWB_BYPASS_EN
    logic q_ma, q_mb, q_mo;

    assign q_ma = a_v && (a_ad == q_addr);
    assign q_mb = b_v && (b_ad == q_addr);
    assign q_mo = regw && (wr == q_addr);

    always_comb begin
        q_hit  = (q_ma || q_mb || q_mo) && !(R0_DISCARD && (q_addr == 5'd0));
        q_data = 32'd0;
        // Youngest value wins: younger buffer, then older buffer, then port.
        if (q_ma && q_mb)
            q_data = age_b ? a_dt : b_dt;
        else if (q_ma)
            q_data = a_dt;
        else if (q_mb)
            q_data = b_dt;
        else if (q_mo)
            q_data = wdata;
    end
`else
    // Without the forwarding lookup the issue logic relies on busy alone.
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Testbench for regwb_arbiter: directed steps in one initial block, a
// negedge write monitor draining an expected-write queue, and a small
// register-file model that commits on the negedge while regw is high.

module tb_regwb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        regw;
    logic [4:0]  wr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic [4:0]  q_addr;
`ifdef REGWB_BYPASS_EN
    logic        q_hit;
    logic [31:0] q_data;
`endif

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf [32];

    regwb_arbiter #(.MAX_WAIT(4), .R0_DISCARD(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .regw    (regw),
        .wr      (wr),
        .wdata   (wdata),
        .busy    (busy)
`ifdef REGWB_BYPASS_EN
        ,
        .q_addr  (q_addr),
        .q_hit   (q_hit),
        .q_data  (q_data)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register file model
    always @(negedge clk)
        if (regw === 1'b1)
            rf[wr] <= wdata;

    // Scoreboard: every port write must match the head of the expected queue
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst === 1'b0 && regw === 1'b1) begin
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr_data", 64'({wr, wdata}), 64'(e));
            end
        end
    end

    task automatic push(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0)
                break;
        end
        @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int a_cnt, b_cnt, ga, gb;

        for (int i = 0; i < 32; i++)
            rf[i] = 32'(i);
        rst = 1'b1;
        a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        q_addr = 5'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_regw",    64'(regw),    64'd0);
        check("rst_wr",      64'(wr),      64'd0);
        check("rst_wdata",   64'(wdata),   64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd1);
        check("rst_b_ready", 64'(b_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Reset between capture and grant loses the write
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        @(negedge clk);
        a_valid = 1'b0;
        check("rstmid_busy_captured", 64'(busy), 64'(32'h1 << 5));
        check("rstmid_regw_captured", 64'(regw), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_busy_cleared", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_regw_quiet", 64'(regw), 64'd0);
        end
        check("rstmid_r5", 64'(rf[5]), 64'd5);

        // Single A write: one cycle of latency, one cycle of regw
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        push(5'd3, 32'h11);
        @(negedge clk);
        a_valid = 1'b0;
        check("single_regw_wait", 64'(regw), 64'd0);
        check("single_busy_buf",  64'(busy), 64'(32'h1 << 3));
        @(negedge clk);
        check("single_regw",      64'(regw),  64'd1);
        check("single_wr",        64'(wr),    64'd3);
        check("single_wdata",     64'(wdata), 64'h11);
        check("single_busy_port", 64'(busy),  64'(32'h1 << 3));
        @(negedge clk);
        check("single_regw_drop", 64'(regw),  64'd0);
        check("single_busy_done", 64'(busy),  64'd0);
        check("single_r3",        64'(rf[3]), 64'h11);

        // Contention, distinct addresses: grants A,A,A,A,B repeating
        a_cnt = 0; b_cnt = 0; ga = 0; gb = 0;
        for (int k = 0; k < 20; k++) begin
            check("cont_a_ready", 64'(a_ready), 64'((k == 0) || (k % 5 != 0)));
            check("cont_b_ready", 64'(b_ready), 64'(k % 5 == 0));
            if (k >= 1) begin
                if (k % 5 == 0) begin
                    push(5'd2, 32'hB0000000 + 32'(gb));
                    gb++;
                end else begin
                    push(5'd1, 32'hA0000000 + 32'(ga));
                    ga++;
                end
            end
            a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA0000000 + 32'(a_cnt);
            b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hB0000000 + 32'(b_cnt);
            if (a_ready) a_cnt++;
            if (b_ready) b_cnt++;
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        // B has aged out again, so it retires before A's last entry
        push(5'd2, 32'hB0000000 + 32'(gb));
        push(5'd1, 32'hA0000000 + 32'(ga));
        drain("cont_drained");

        // Same address, B captured first: B written first, A last
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
        push(5'd7, 32'hB);
        @(negedge clk);
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA;
        push(5'd7, 32'hA);
        @(negedge clk);
        a_valid = 1'b0;
        check("same_busy", 64'(busy), 64'(32'h1 << 7));
        drain("same_drained");
        check("same_r7", 64'(rf[7]), 64'hA);

        // Same address, same-edge capture: B counts as older
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h9A;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9B;
        push(5'd9, 32'h9B);
        push(5'd9, 32'h9A);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        drain("sameedge_drained");
        check("sameedge_r9", 64'(rf[9]), 64'h9A);

        // Register 0 discard alongside a real B write
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
        push(5'd4, 32'h44);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("r0_busy_buf", 64'(busy),    64'(32'h1 << 4));
        check("r0_a_ready",  64'(a_ready), 64'd1);
        @(negedge clk);
        check("r0_busy_port", 64'(busy), 64'(32'h1 << 4));
        check("r0_wr",        64'(wr),   64'd4);
        drain("r0_drained");
        check("r0_r0", 64'(rf[0]), 64'd0);
        check("r0_r4", 64'(rf[4]), 64'h44);

        // Back-to-back A writes
        for (int i = 0; i < 4; i++) begin
            check("b2b_a_ready", 64'(a_ready), 64'd1);
            if (i >= 2) begin
                check("b2b_regw", 64'(regw), 64'd1);
                check("b2b_wr",   64'(wr),   64'(10 + i - 2));
            end
            a_valid = 1'b1; a_addr = 5'(10 + i); a_data = 32'hC0 + 32'(i);
            push(5'(10 + i), 32'hC0 + 32'(i));
            @(negedge clk);
        end
        a_valid = 1'b0;
        check("b2b_regw_last", 64'(regw), 64'd1);
        check("b2b_wr_last",   64'(wr),   64'd12);
`ifdef REGWB_BYPASS_EN
        q_addr = 5'd13;
        #1;
        check("byp_hit",  64'(q_hit),  64'd1);
        check("byp_data", 64'(q_data), 64'hC3);
        q_addr = 5'd0;
        #1;
        check("byp_r0_hit", 64'(q_hit), 64'd0);
`endif
        drain("b2b_drained");
        check("b2b_r13", 64'(rf[13]), 64'hC3);
        check("final_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
